// File: rtl/spike_layer_if.sv
// Bus bundle for spike_layer: step handshake, weight-write port and membrane monitor.
// The master side drives stimulus and writes; the slave side is the neuron layer.
interface spike_layer_if #(
  parameter int unsigned N_IN  = 7,
  parameter int unsigned N_OUT = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC_W = $clog2(N_IN * (2 ** WIDTH)) + 2
);
  localparam int unsigned IW = $clog2(N_IN);
  localparam int unsigned OW = $clog2(N_OUT);

  logic [N_IN-1:0]         pixels;
  logic                    tick;
  logic                    busy;
  logic                    done;
  logic [N_OUT-1:0]        spikes;
  logic                    wr_en;
  logic [OW-1:0]           wr_out;
  logic [IW-1:0]           wr_in;
  logic [WIDTH:0]          wr_data;
  logic                    wr_err;
  logic [OW-1:0]           mon_sel;
  logic signed [ACC_W-1:0] mon_out;

  modport master (
    output pixels, tick, wr_en, wr_out, wr_in, wr_data, mon_sel,
    input  busy, done, spikes, wr_err, mon_out
  );

  modport slave (
    input  pixels, tick, wr_en, wr_out, wr_in, wr_data, mon_sel,
    output busy, done, spikes, wr_err, mon_out
  );
endinterface

// File: rtl/spike_layer.sv
// Time-multiplexed layer of N_OUT integrate-and-fire neurons over N_IN binary inputs.
// Define SPIKE_REFRAC_EN to add per-neuron refractory counters (REFRAC steps after a spike).
module spike_layer #(
  parameter int unsigned N_IN       = 7,
  parameter int unsigned N_OUT      = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ACC_W      = $clog2(N_IN * (2 ** WIDTH)) + 2,
  parameter int          THRESH     = 500,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int unsigned REFRAC     = 2
) (
  input logic          clk,
  input logic          rst,
  spike_layer_if.slave bus
);
  localparam int unsigned IW = $clog2(N_IN);
  localparam logic signed [ACC_W:0] SAT_MAX = {2'b00, {(ACC_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {2'b11, {(ACC_W - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAccum, StFire} state_e;

  state_e                  state_q;
  logic [IW-1:0]           idx_q;
  logic [N_IN-1:0]         pix_q;
  logic [WIDTH:0]          w_q   [N_OUT][N_IN];
  logic signed [ACC_W-1:0] mem_q [N_OUT];
  logic signed [ACC_W-1:0] mem_d [N_OUT];
  logic [N_OUT-1:0]        spk_d;
  logic [N_OUT-1:0]        active;
  logic [N_OUT-1:0]        spikes_q;
  logic                    busy_q, done_q, wr_err_q, wr_ok;
  logic signed [ACC_W-1:0] mon_q;

  // Sign-magnitude add with clamping; -0 contributes nothing.
  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] m,
                                                      input logic [WIDTH:0] w);
    logic signed [ACC_W:0]   mag;
    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W-1:0] res;
    mag = $signed({{(ACC_W + 1 - WIDTH){1'b0}}, w[WIDTH-1:0]});
    sum = {m[ACC_W-1], m} + (w[WIDTH] ? -mag : mag);
    if (sum > SAT_MAX)      res = SAT_MAX[ACC_W-1:0];
    else if (sum < SAT_MIN) res = SAT_MIN[ACC_W-1:0];
    else                    res = sum[ACC_W-1:0];
    return res;
  endfunction

`ifdef SPIKE_REFRAC_EN
  localparam int unsigned RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  logic [RW-1:0] refr_q [N_OUT];

  always_comb begin
    for (int j = 0; j < N_OUT; j++) active[j] = (refr_q[j] == '0);
  end
`else
  assign active = '1;
`endif

  assign wr_ok = bus.wr_en && (state_q == StIdle) && !bus.tick &&
                 (int'(bus.wr_out) < N_OUT) && (int'(bus.wr_in) < N_IN);

  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      mem_d[j] = mem_q[j];
      spk_d[j] = 1'b0;
      if (state_q == StAccum) begin
        if (pix_q[idx_q] && active[j]) mem_d[j] = sat_add(mem_q[j], w_q[j][idx_q]);
      end else if (state_q == StFire) begin
        if (!active[j]) begin
          mem_d[j] = '0;
        end else if (int'(mem_q[j]) >= THRESH) begin
          spk_d[j] = 1'b1;
          mem_d[j] = '0;
        end else begin
          mem_d[j] = mem_q[j] - (mem_q[j] >>> LEAK_SHIFT);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      pix_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      spikes_q <= '0;
      wr_err_q <= 1'b0;
      mon_q    <= '0;
      for (int j = 0; j < N_OUT; j++) begin
        mem_q[j] <= '0;
        for (int i = 0; i < N_IN; i++) w_q[j][i] <= '0;
`ifdef SPIKE_REFRAC_EN
        refr_q[j] <= '0;
`endif
      end
    end else begin
      done_q   <= 1'b0;
      wr_err_q <= bus.wr_en && !wr_ok;
      mon_q    <= (int'(bus.mon_sel) < N_OUT) ? mem_q[bus.mon_sel] : '0;
      for (int j = 0; j < N_OUT; j++) mem_q[j] <= mem_d[j];
      if (wr_ok) w_q[bus.wr_out][bus.wr_in] <= bus.wr_data;

      case (state_q)
        StIdle: begin
          if (bus.tick) begin
            pix_q   <= bus.pixels;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StAccum;
          end
        end
        StAccum: begin
          if (idx_q == IW'(N_IN - 1)) state_q <= StFire;
          else                        idx_q   <= idx_q + 1'b1;
        end
        StFire: begin
          state_q  <= StIdle;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          spikes_q <= spk_d;
`ifdef SPIKE_REFRAC_EN
          for (int j = 0; j < N_OUT; j++) begin
            if (refr_q[j] != '0) refr_q[j] <= refr_q[j] - 1'b1;
            else if (spk_d[j])   refr_q[j] <= RW'(REFRAC);
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.spikes  = spikes_q;
  assign bus.wr_err  = wr_err_q;
  assign bus.mon_out = mon_q;
endmodule

// File: tb/tb_spike_layer.sv
// Self-checking bench for spike_layer: directed vector table, protocol/reset sequences and
// randomized steps against an arithmetic model of the neuron layer.
module tb_spike_layer;
  localparam int unsigned N_IN   = 7;
  localparam int unsigned N_OUT  = 4;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned ACC_W  = 13;
  localparam int unsigned REFRAC = 2;
  localparam int          THRESH = 500;
  localparam int          SAT_HI = 4095;
  localparam int          SAT_LO = -4096;

  logic clk = 1'b0;
  logic rst;

  spike_layer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(WIDTH), .ACC_W(ACC_W)) bus ();

  spike_layer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(WIDTH), .ACC_W(ACC_W),
    .THRESH(THRESH), .LEAK_SHIFT(3), .REFRAC(REFRAC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: plain integers.
  int m_mem [N_OUT];
  int m_w   [N_OUT][N_IN];
  int m_ref [N_OUT];

  typedef struct {
    bit         load;
    int         nrn;
    logic [8:0] wdata;
    logic [6:0] pix;
    logic [3:0] spk;
    int         sel;
    int         mon;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int j = 0; j < N_OUT; j++) begin
      m_mem[j] = 0;
      m_ref[j] = 0;
      for (int i = 0; i < N_IN; i++) m_w[j][i] = 0;
    end
  endfunction

  function automatic int sm_value(input logic [8:0] d);
    return d[8] ? -int'(d[7:0]) : int'(d[7:0]);
  endfunction

  function automatic int floor_div8(input int v);
    return (v >= 0) ? v / 8 : -((-v + 7) / 8);
  endfunction

  function automatic logic [3:0] m_step(input logic [6:0] pix);
    logic [3:0] s = '0;
    for (int j = 0; j < N_OUT; j++) begin
      if (m_ref[j] > 0) begin
        m_ref[j]--;
        m_mem[j] = 0;
        continue;
      end
      for (int i = 0; i < N_IN; i++) begin
        if (pix[i]) begin
          m_mem[j] += m_w[j][i];
          if (m_mem[j] > SAT_HI) m_mem[j] = SAT_HI;
          if (m_mem[j] < SAT_LO) m_mem[j] = SAT_LO;
        end
      end
      if (m_mem[j] >= THRESH) begin
        s[j] = 1'b1;
        m_mem[j] = 0;
`ifdef SPIKE_REFRAC_EN
        m_ref[j] = REFRAC;
`endif
      end else begin
        m_mem[j] -= floor_div8(m_mem[j]);
      end
    end
    return s;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    m_reset();
  endtask

  task automatic wr(input int o, input int i, input logic [8:0] d);
    bit exp_err;
    exp_err     = (i >= N_IN) || (o >= N_OUT);
    bus.wr_en   = 1'b1;
    bus.wr_out  = 2'(o);
    bus.wr_in   = 3'(i);
    bus.wr_data = d;
    cycle();
    bus.wr_en = 1'b0;
    check("wr_err", bus.wr_err, exp_err);
    if (!exp_err) m_w[o][i] = sm_value(d);
  endtask

  task automatic wait_done(input int start, output int lat, output bit gap);
    lat = start;
    gap = 1'b0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy !== 1'b1) gap = 1'b1;
      cycle();
      lat++;
    end
  endtask

  task automatic run_step(input logic [6:0] pix, output logic [3:0] dut_spk,
                          output logic [3:0] exp_spk);
    int lat;
    bit gap;
    bus.pixels = pix;
    bus.tick   = 1'b1;
    cycle();
    bus.tick = 1'b0;
    check("busy_start", bus.busy, 1);
    wait_done(1, lat, gap);
    check("done_latency", lat, N_IN + 2);
    check("busy_gap", gap, 0);
    check("busy_at_done", bus.busy, 0);
    dut_spk = bus.spikes;
    exp_spk = m_step(pix);
  endtask

  task automatic read_mon(input int sel, output int v);
    bus.mon_sel = 2'(sel);
    cycle();
    v = int'(bus.mon_out);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] ds, es;
    logic [6:0] pix;
    int         v, lat, cnt, sel;
    bit         gap;
    logic       exp6 [4];

    bus.pixels  = '0;
    bus.tick    = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_out  = '0;
    bus.wr_in   = '0;
    bus.wr_data = '0;
    bus.mon_sel = '0;
    rst         = 1'b1;
    cycle();
    do_reset();

    // Reset state and a step with all-zero weights
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_spikes", bus.spikes, 0);
    check("rst_wr_err", bus.wr_err, 0);
    check("rst_mon", bus.mon_out, 0);
    run_step(7'h7F, ds, es);
    check("zero_spikes", ds, 4'b0000);
    cycle();
    check("done_pulse", bus.done, 0);
    read_mon(0, v);
    check("zero_mon", v, 0);

    tbl[0] = '{1'b1, 0, 9'h064, 7'b0101010, 4'b0000, 0, 263};
    tbl[1] = '{1'b0, 0, 9'h064, 7'b0101010, 4'b0001, 0, 0};
    tbl[2] = '{1'b1, 1, 9'h1FF, 7'h7F,      4'b0000, 1, -1561};
    tbl[3] = '{1'b0, 1, 9'h1FF, 7'h7F,      4'b0000, 1, -2927};
    tbl[4] = '{1'b0, 1, 9'h1FF, 7'h7F,      4'b0000, 1, -3584};
    for (int k = 0; k < 5; k++) begin
      if (tbl[k].load) begin
        do_reset();
        for (int i = 0; i < N_IN; i++) wr(tbl[k].nrn, i, tbl[k].wdata);
      end
      run_step(tbl[k].pix, ds, es);
      check($sformatf("tbl%0d_spikes", k), ds, tbl[k].spk);
      read_mon(tbl[k].sel, v);
      check($sformatf("tbl%0d_mon", k), v, tbl[k].mon);
    end

    // Tick raised mid-step must be dropped
    do_reset();
    bus.pixels = 7'h7F;
    bus.tick   = 1'b1;
    cycle();
    bus.tick = 1'b0;
    cycle();
    cycle();
    bus.tick = 1'b1;
    cycle();
    bus.tick = 1'b0;
    cnt = 0;
    for (int c = 0; c < 25; c++) begin
      if (bus.done) cnt++;
      cycle();
    end
    check("ignored_tick_dones", cnt, 1);
    check("ignored_tick_idle", bus.busy, 0);
    es = m_step(7'h7F);

    // Write while busy is rejected and leaves the weight intact
    do_reset();
    wr(2, 0, 9'h032);
    bus.pixels = '0;
    bus.tick   = 1'b1;
    cycle();
    bus.tick    = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_out  = 2'd2;
    bus.wr_in   = 3'd0;
    bus.wr_data = 9'h0FF;
    cycle();
    bus.wr_en = 1'b0;
    check("wr_busy_err", bus.wr_err, 1);
    cycle();
    check("wr_err_pulse", bus.wr_err, 0);
    wait_done(3, lat, gap);
    check("wr_busy_latency", lat, N_IN + 2);
    es = m_step(7'h00);
    run_step(7'h01, ds, es);
    check("wr_busy_spikes", ds, es);
    read_mon(2, v);
    check("wr_busy_weight", v, m_mem[2]);

    // Out-of-range input address
    wr(1, 7, 9'h010);

    // Tick and write in the same idle cycle: tick wins, write rejected
    bus.pixels  = 7'h01;
    bus.tick    = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_out  = 2'd2;
    bus.wr_in   = 3'd0;
    bus.wr_data = 9'h0FF;
    cycle();
    bus.tick  = 1'b0;
    bus.wr_en = 1'b0;
    check("tick_wr_err", bus.wr_err, 1);
    check("tick_wins_busy", bus.busy, 1);
    wait_done(1, lat, gap);
    check("tick_wins_latency", lat, N_IN + 2);
    es = m_step(7'h01);
    check("tick_wins_spikes", bus.spikes, es);
    read_mon(2, v);
    check("tick_wins_weight", v, m_mem[2]);

    // Reset in the middle of a step
    do_reset();
    for (int i = 0; i < N_IN; i++) wr(3, i, 9'h064);
    wr(2, 0, 9'h064);
    run_step(7'h7F, ds, es);
    check("pre_rst_spikes", ds, es);
    bus.pixels = 7'h7F;
    bus.tick   = 1'b1;
    cycle();
    bus.tick = 1'b0;
    cycle();
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    m_reset();
    check("mid_rst_busy", bus.busy, 0);
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (bus.done) cnt++;
      cycle();
    end
    check("mid_rst_no_done", cnt, 0);
    check("mid_rst_spikes", bus.spikes, 0);
    for (int n = 0; n < N_OUT; n++) begin
      read_mon(n, v);
      check($sformatf("mid_rst_mon%0d", n), v, 0);
    end
    run_step(7'h7F, ds, es);
    check("mid_rst_w_spikes", ds, es);
    read_mon(3, v);
    check("mid_rst_weights", v, m_mem[3]);

    // Strong neuron over four steps: refractory gaps when enabled
`ifdef SPIKE_REFRAC_EN
    exp6 = '{1'b1, 1'b0, 1'b0, 1'b1};
`else
    exp6 = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    do_reset();
    for (int i = 0; i < N_IN; i++) wr(0, i, 9'h0FF);
    for (int s = 0; s < 4; s++) begin
      run_step(7'h7F, ds, es);
      check($sformatf("strong%0d_spike0", s), ds[0], exp6[s]);
      read_mon(0, v);
      check($sformatf("strong%0d_mon0", s), v, 0);
    end

    // Randomized weights and pixels against the model
    do_reset();
    for (int o = 0; o < N_OUT; o++) begin
      for (int i = 0; i < N_IN; i++) begin
        wr(o, i, {($urandom_range(0, 2) == 0), 8'($urandom)});
      end
    end
    for (int k = 0; k < 4; k++) wr($urandom_range(0, N_OUT - 1), 7, 9'($urandom));
    for (int s = 0; s < 40; s++) begin
      pix = 7'($urandom);
      run_step(pix, ds, es);
      check($sformatf("rand%0d_spikes", s), ds, es);
      sel = $urandom_range(0, N_OUT - 1);
      read_mon(sel, v);
      check($sformatf("rand%0d_mon%0d", s, sel), v, m_mem[sel]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
